// File: rtl/rs_flag_pkg.sv
// Shared definitions for the round-robin set/reset flag scheduler.
// Opcode encoding, opcode type and an index-width helper.
package rs_flag_pkg;

  typedef logic [1:0] flag_op_t;

  localparam flag_op_t OP_NOP = 2'b00;
  localparam flag_op_t OP_SET = 2'b01;
  localparam flag_op_t OP_CLR = 2'b10;
  localparam flag_op_t OP_TAS = 2'b11;

  // Width needed to index n items; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first eligible requester at or after
// the pointer, wrapping N-1 -> 0. The pointer register is owned by the caller.
module rr_arb
  import rs_flag_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx,
  output logic          valid
);

  int          pos;
  logic [PW-1:0] cand;

  // Walk outward from the pointer and take the first eligible requester
  always_comb begin
    grant = '0;
    gidx  = '0;
    valid = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      pos  = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      cand = PW'(pos);
      if (!valid && elig[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = cand;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/rs_flag_sched.sv
// Round-robin scheduler serialising set / clear / test-and-set operations on
// a shared bank of status flags; at most one flag changes per clock.
module rs_flag_sched
  import rs_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = idx_width(NFLAG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 rdata,
  output logic                 err,
  output logic [NFLAG-1:0]     flag_q,
  output logic [NFLAG-1:0]     flag_qb
);

  localparam int PW = idx_width(NREQ);

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    ptr_next;
  logic             valid;
  flag_op_t         gop;
  logic [IDXW-1:0]  gflag;
  logic             in_range;
  logic             cur;
  logic [NFLAG-1:0] flag_next;

  // A requester acked this cycle sits out one arbitration round
  assign elig     = req & ~ack;
  assign flag_qb  = ~flag_q;
  assign in_range = (int'(gflag) < NFLAG);
  assign ptr_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

  rr_arb #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx),
    .valid (valid)
  );

  // Route the winning requester's opcode and flag index
  always_comb begin
    gop   = OP_NOP;
    gflag = '0;
    for (int i = 0; i < NREQ; i++) begin
      gop   = grant[i] ? flag_op_t'(op[2*i +: 2]) : gop;
      gflag = grant[i] ? idx[IDXW*i +: IDXW] : gflag;
    end
  end

  // Sample the target flag and compute its single-bit update
  always_comb begin
    cur       = 1'b0;
    flag_next = flag_q;
    for (int f = 0; f < NFLAG; f++) begin
      if (valid && (gflag == IDXW'(f))) begin
        cur = flag_q[f];
        case (gop)
          OP_SET:  flag_next[f] = 1'b1;
          OP_CLR:  flag_next[f] = 1'b0;
          OP_TAS:  flag_next[f] = flag_q[f] ? flag_q[f] : 1'b1;
          default: flag_next[f] = flag_q[f];
        endcase
      end else begin
        flag_next[f] = flag_q[f];
      end
    end
  end

  // Flag bank, acknowledge/response registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
      ack    <= '0;
      rdata  <= 1'b0;
      err    <= 1'b0;
      ptr    <= '0;
    end else begin
      flag_q <= flag_next;
      ack    <= grant;
      if (valid) begin
        rdata <= cur;
        err   <= ~in_range;
        ptr   <= ptr_next;
      end else begin
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_flag_sched.sv
// Self-checking bench for rs_flag_sched: directed scenarios plus randomized
// traffic compared against a behavioural flag-bank model.
module tb_rs_flag_sched;

  localparam int NREQ   = 4;
  localparam int NFLAG  = 8;
  localparam int IDXW   = 3;
  localparam int NFLAG6 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NREQ-1:0]      req;
  logic [1:0]           op_a  [NREQ];
  logic [2:0]           idx_a [NREQ];
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      ack;
  logic                 rdata, err;
  logic [NFLAG-1:0]     flag_q, flag_qb;

  logic [NREQ-1:0]      req6;
  logic [1:0]           op6_a  [NREQ];
  logic [2:0]           idx6_a [NREQ];
  logic [2*NREQ-1:0]    op6;
  logic [IDXW*NREQ-1:0] idx6;
  logic [NREQ-1:0]      ack6;
  logic                 rdata6, err6;
  logic [NFLAG6-1:0]    flag6_q, flag6_qb;

  int total = 0;
  int bad   = 0;

  // model state
  bit            mflag [NFLAG];
  int            mptr;
  int            mlast;
  logic [NREQ-1:0]  exp_ack;
  logic             exp_rdata, exp_err;
  logic [NFLAG-1:0] exp_flag;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op[2*i +: 2]        = op_a[i];
      idx[IDXW*i +: IDXW] = idx_a[i];
      op6[2*i +: 2]       = op6_a[i];
      idx6[IDXW*i +: IDXW]= idx6_a[i];
    end
  end

  rs_flag_sched #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .ack(ack), .rdata(rdata), .err(err), .flag_q(flag_q), .flag_qb(flag_qb)
  );

  rs_flag_sched #(.NREQ(NREQ), .NFLAG(NFLAG6)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6),
    .ack(ack6), .rdata(rdata6), .err(err6), .flag_q(flag6_q), .flag_qb(flag6_qb)
  );

  task automatic model_reset();
    for (int f = 0; f < NFLAG; f++) mflag[f] = 1'b0;
    mptr      = 0;
    mlast     = -1;
    exp_ack   = '0;
    exp_rdata = 1'b0;
    exp_err   = 1'b0;
    exp_flag  = '0;
  endtask

  // One scheduling decision from the current requests, applied to the model
  task automatic model_step();
    int g, c, f;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (mptr + k) % NREQ;
      if (g < 0 && req[c] && c != mlast) g = c;
    end
    exp_ack = '0;
    exp_err = 1'b0;
    if (g >= 0) begin
      f = int'(idx_a[g]);
      exp_ack[g] = 1'b1;
      if (f >= NFLAG) begin
        exp_err   = 1'b1;
        exp_rdata = 1'b0;
      end else begin
        exp_rdata = mflag[f];
        case (op_a[g])
          2'b01, 2'b11: mflag[f] = 1'b1;
          2'b10:        mflag[f] = 1'b0;
          default:      mflag[f] = mflag[f];
        endcase
      end
      mptr  = (g + 1) % NREQ;
      mlast = g;
    end else begin
      mlast = -1;
    end
    for (int i = 0; i < NFLAG; i++) exp_flag[i] = mflag[i];
  endtask

  task automatic clear_inputs();
    req  = '0;
    req6 = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 2'b00; idx_a[i] = 3'd0; op6_a[i] = 2'b00; idx6_a[i] = 3'd0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2; rst = 1'b1;
    #3; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    #12; rst = 1'b0;
    total++; if (flag_q !== 8'h00 || flag_qb !== 8'hFF || ack !== 4'b0000) begin
      bad++; $display("FAIL reset_state: flag_q=%h flag_qb=%h ack=%b want 00/FF/0000", flag_q, flag_qb, ack);
    end
    req[0] = 1'b1; op_a[0] = 2'b01; idx_a[0] = 3'd6;
    tick();
    req = '0;
    total++; if (ack !== 4'b0001 || flag_q !== 8'h40) begin
      bad++; $display("FAIL pre_reset_set: ack=%b flag_q=%h want 0001/40", ack, flag_q);
    end
    #3; rst = 1'b1; #1;
    total++; if (flag_q !== 8'h00 || flag_qb !== 8'hFF || ack !== 4'b0000 || rdata !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL async_reset: flag_q=%h flag_qb=%h ack=%b rdata=%b err=%b want 00/FF/0000/0/0",
                      flag_q, flag_qb, ack, rdata, err);
    end
    #2; rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (ack !== 4'b0000) begin
        bad++; $display("FAIL idle_ack[%0d]: ack=%b want 0000", c, ack);
      end
    end
  endtask

  task automatic test_set_clear();
    req[0] = 1'b1; op_a[0] = 2'b01; idx_a[0] = 3'd3;
    tick();
    total++; if (ack !== 4'b0001 || rdata !== 1'b0 || flag_q !== 8'h08 || flag_qb !== 8'hF7) begin
      bad++; $display("FAIL set3: ack=%b rdata=%b flag_q=%h flag_qb=%h want 0001/0/08/F7", ack, rdata, flag_q, flag_qb);
    end
    op_a[0] = 2'b10;
    tick();
    total++; if (ack !== 4'b0000) begin
      bad++; $display("FAIL back_to_back_block: ack=%b want 0000", ack);
    end
    tick();
    req[0] = 1'b0;
    total++; if (ack !== 4'b0001 || rdata !== 1'b1 || flag_q !== 8'h00) begin
      bad++; $display("FAIL clear3: ack=%b rdata=%b flag_q=%h want 0001/1/00", ack, rdata, flag_q);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [5];
    logic [NREQ-1:0] prev;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    do_reset();
    req  = 4'b1111;
    prev = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (ack !== seq[c] || ack !== exp_ack || (ack & prev) !== 4'b0000) begin
        bad++; $display("FAIL rr_seq[%0d]: ack=%b want %b", c, ack, seq[c]);
      end
      prev = ack;
    end
    req = '0;
    tick();
  endtask

  task automatic test_tas_contention();
    do_reset();
    req = 4'b0110;
    op_a[1] = 2'b11; idx_a[1] = 3'd5;
    op_a[2] = 2'b11; idx_a[2] = 3'd5;
    tick();
    req[1] = 1'b0;
    total++; if (ack !== 4'b0010 || rdata !== 1'b0 || flag_q !== 8'h20) begin
      bad++; $display("FAIL tas_first: ack=%b rdata=%b flag_q=%h want 0010/0/20", ack, rdata, flag_q);
    end
    tick();
    req[2] = 1'b0;
    total++; if (ack !== 4'b0100 || rdata !== 1'b1 || flag_q !== 8'h20) begin
      bad++; $display("FAIL tas_second: ack=%b rdata=%b flag_q=%h want 0100/1/20", ack, rdata, flag_q);
    end
    tick();
    total++; if (ack !== 4'b0000 || err !== 1'b0 || rdata !== 1'b1) begin
      bad++; $display("FAIL tas_idle: ack=%b err=%b rdata=%b want 0000/0/1", ack, err, rdata);
    end
  endtask

  task automatic test_out_of_range();
    logic [NREQ-1:0]   e_ack [4];
    logic              e_err [4];
    logic [NFLAG6-1:0] e_flg [4];
    do_reset();
    e_ack[0] = 4'b0001; e_err[0] = 1'b0; e_flg[0] = 6'h04;
    e_ack[1] = 4'b0010; e_err[1] = 1'b1; e_flg[1] = 6'h04;
    e_ack[2] = 4'b0100; e_err[2] = 1'b0; e_flg[2] = 6'h24;
    e_ack[3] = 4'b1000; e_err[3] = 1'b1; e_flg[3] = 6'h24;
    op6_a[0] = 2'b01; idx6_a[0] = 3'd2;
    op6_a[1] = 2'b01; idx6_a[1] = 3'd7;
    op6_a[2] = 2'b01; idx6_a[2] = 3'd5;
    op6_a[3] = 2'b10; idx6_a[3] = 3'd6;
    for (int s = 0; s < 4; s++) begin
      req6 = '0;
      req6[s] = 1'b1;
      tick();
      total++; if (ack6 !== e_ack[s] || err6 !== e_err[s] || rdata6 !== 1'b0 || flag6_q !== e_flg[s] ||
                   flag6_qb !== ~e_flg[s]) begin
        bad++; $display("FAIL oor_step[%0d]: ack=%b err=%b rdata=%b flag=%h want %b/%b/0/%h",
                        s, ack6, err6, rdata6, flag6_q, e_ack[s], e_err[s], e_flg[s]);
      end
    end
    req6 = '0;
    tick();
    total++; if (ack6 !== 4'b0000 || err6 !== 1'b0) begin
      bad++; $display("FAIL oor_idle: ack=%b err=%b want 0000/0", ack6, err6);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    req[1] = 1'b1; op_a[1] = 2'b01; idx_a[1] = 3'd4;
    tick();
    total++; if (ack !== 4'b0010 || flag_q !== 8'h10) begin
      bad++; $display("FAIL mid_setup: ack=%b flag_q=%h want 0010/10", ack, flag_q);
    end
    req = 4'b1010; op_a[1] = 2'b00; op_a[3] = 2'b00;
    #2; rst = 1'b1; #1;
    total++; if (flag_q !== 8'h00 || ack !== 4'b0000) begin
      bad++; $display("FAIL mid_clear: flag_q=%h ack=%b want 00/0000", flag_q, ack);
    end
    #3; rst = 1'b0;
    model_reset();
    tick();
    total++; if (ack !== 4'b0010 || flag_q !== 8'h00) begin
      bad++; $display("FAIL mid_restart: ack=%b flag_q=%h want 0010/00", ack, flag_q);
    end
    tick();
    req = '0;
    total++; if (ack !== 4'b1000) begin
      bad++; $display("FAIL mid_next: ack=%b want 1000", ack);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      total++; if (ack !== exp_ack || rdata !== exp_rdata || err !== exp_err ||
                   flag_q !== exp_flag || flag_qb !== ~exp_flag) begin
        bad++; $display("FAIL rand[%0d]: ack=%b rdata=%b err=%b flag_q=%h want %b/%b/%b/%h",
                        c, ack, rdata, err, flag_q, exp_ack, exp_rdata, exp_err, exp_flag);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else begin
            op_a[i]  = 2'($urandom_range(3, 0));
            idx_a[i] = 3'($urandom_range(7, 0));
          end
        end else if (!req[i] && $urandom_range(99, 0) < 40) begin
          req[i]   = 1'b1;
          op_a[i]  = 2'($urandom_range(3, 0));
          idx_a[i] = 3'($urandom_range(7, 0));
        end
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_round_robin();
    test_tas_contention();
    test_out_of_range();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
